// File: rtl/arch_map_table_stream.sv
// Committed arch->phys map: updated at retire (Told released to the free list), streamed to the RAT on recovery.
// Lookup/Told are combinational, writes land next edge; each recovery beat holds until recov_ready_i is high.
module arch_map_table_stream #(
   parameter int ARCH_REGS     = 64,
   parameter int PHYS_REGS     = 128,
   parameter int COMMIT_WIDTH  = 2,
   parameter int READ_PORTS    = 2,
   parameter int RECOVER_WIDTH = 8,
   parameter bit ZERO_REG_EN   = 1'b1,
   localparam int AW = $clog2(ARCH_REGS),
   localparam int PW = $clog2(PHYS_REGS)
) (
   input  logic                                    clock,
   input  logic                                    reset,
   input  logic [COMMIT_WIDTH-1:0]                 commit_valid_i,
   input  logic [COMMIT_WIDTH-1:0][AW-1:0]         commit_arch_i,
   input  logic [COMMIT_WIDTH-1:0][PW-1:0]         commit_phys_i,
   output logic                                    commit_ready_o,
   output logic [COMMIT_WIDTH-1:0]                 told_valid_o,
   output logic [COMMIT_WIDTH-1:0][PW-1:0]         told_phys_o,
   input  logic [READ_PORTS-1:0][AW-1:0]           rd_arch_i,
   output logic [READ_PORTS-1:0][PW-1:0]           rd_phys_o,
   input  logic                                    recover_req_i,
   output logic                                    recov_valid_o,
   input  logic                                    recov_ready_i,
   output logic [AW-1:0]                           recov_base_o,
   output logic [RECOVER_WIDTH-1:0]                recov_lane_valid_o,
   output logic [RECOVER_WIDTH-1:0][PW-1:0]        recov_phys_o,
   output logic                                    recover_done_o,
   output logic [ARCH_REGS-1:0][PW-1:0]            snapshot_o
);

   localparam int NBEATS = (ARCH_REGS + RECOVER_WIDTH - 1) / RECOVER_WIDTH;
   localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STREAM,
      ST_DONE
   } state_t;

   state_t                         state_q, state_d;
   logic [BW-1:0]                  beat_q, beat_d;
   logic [ARCH_REGS-1:0][PW-1:0]   table_q, table_d;
   int                             beat_base;
   int                             lane_idx;

   function automatic logic in_map(input logic [AW-1:0] a);
      return {1'b0, a} < (AW+1)'(ARCH_REGS);
   endfunction

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         beat_q  <= '0;
         for (int i = 0; i < ARCH_REGS; i++) begin
            table_q[i] <= PW'(i);
         end
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         table_q <= table_d;
      end
   end

   // Slots fold into table_d in age order, so each Told sees the older slots' writes first.
   always_comb begin
      table_d        = table_q;
      commit_ready_o = (state_q == ST_IDLE);
      told_valid_o   = '0;
      told_phys_o    = '0;
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
         if (commit_valid_i[k] && commit_ready_o && !reset && in_map(commit_arch_i[k]) &&
             !(ZERO_REG_EN && (commit_arch_i[k] == '0))) begin
            told_valid_o[k]           = 1'b1;
            told_phys_o[k]            = table_d[commit_arch_i[k]];
            table_d[commit_arch_i[k]] = commit_phys_i[k];
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      beat_d         = beat_q;
      recover_done_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (recover_req_i) begin
               state_d = ST_STREAM;
               beat_d  = '0;
            end
         end
         ST_STREAM: begin
            if (recov_ready_i) begin
               if (beat_q == LAST_BEAT) begin
                  state_d = ST_DONE;
                  beat_d  = '0;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         ST_DONE: begin
            recover_done_o = 1'b1;
            state_d        = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign beat_base = int'(beat_q) * RECOVER_WIDTH;

   // Lanes past the end of the map (last beat of a non-multiple size) drive zero.
   always_comb begin
      recov_valid_o      = (state_q == ST_STREAM);
      recov_base_o       = '0;
      recov_lane_valid_o = '0;
      recov_phys_o       = '0;
      lane_idx           = 0;
      if (recov_valid_o) begin
         recov_base_o = AW'(beat_base);
         for (int l = 0; l < RECOVER_WIDTH; l++) begin
            lane_idx = beat_base + l;
            if (lane_idx < ARCH_REGS) begin
               recov_lane_valid_o[l] = 1'b1;
               recov_phys_o[l]       = table_q[lane_idx[AW-1:0]];
            end
         end
      end
   end

   always_comb begin
      for (int p = 0; p < READ_PORTS; p++) begin
         rd_phys_o[p] = in_map(rd_arch_i[p]) ? table_q[rd_arch_i[p]] : '0;
      end
   end

   assign snapshot_o = table_q;

   // The RAT is being restored from this map, so it must not move until IDLE.
   a_frozen_outside_idle : assert property (@(posedge clock) disable iff (reset)
      (state_q != ST_IDLE) |=> (table_q == $past(table_q)));

   a_beat_held_on_stall : assert property (@(posedge clock) disable iff (reset)
      (recov_valid_o && !recov_ready_i) |=> ($stable(recov_base_o) && $stable(recov_phys_o)));

endmodule

// File: tb/tb_arch_map_table_stream.sv
// Randomized bench for arch_map_table_stream: a 64-entry and a 60-entry instance share stimulus and are
// checked every cycle against a table/beat-counter model, plus literal checks from the directed scenarios.
module tb_arch_map_table_stream;
   localparam int AW = 6, PW = 7, CW = 2, RP = 2, RW = 8, NB = 8;

   logic                      clock = 1'b0;
   logic                      reset;
   logic [CW-1:0]             commit_valid_i;
   logic [CW-1:0][AW-1:0]     commit_arch_i;
   logic [CW-1:0][PW-1:0]     commit_phys_i;
   logic [RP-1:0][AW-1:0]     rd_arch_i;
   logic                      recover_req_i;
   logic                      recov_ready_i;

   logic                      ready_a, ready_b, rv_a, rv_b, done_a, done_b;
   logic [CW-1:0]             tv_a, tv_b;
   logic [CW-1:0][PW-1:0]     tp_a, tp_b;
   logic [RP-1:0][PW-1:0]     rp_a, rp_b;
   logic [AW-1:0]             rb_a, rb_b;
   logic [RW-1:0]             rlv_a, rlv_b;
   logic [RW-1:0][PW-1:0]     rph_a, rph_b;
   logic [63:0][PW-1:0]       snap_a;
   logic [59:0][PW-1:0]       snap_b;
   logic [63:0][PW-1:0]       snap_b_ext;

   assign snap_b_ext = {{(4*PW){1'b0}}, snap_b};

   always #5 clock = ~clock;

   arch_map_table_stream u_a (
      .clock(clock), .reset(reset),
      .commit_valid_i(commit_valid_i), .commit_arch_i(commit_arch_i), .commit_phys_i(commit_phys_i),
      .commit_ready_o(ready_a), .told_valid_o(tv_a), .told_phys_o(tp_a),
      .rd_arch_i(rd_arch_i), .rd_phys_o(rp_a),
      .recover_req_i(recover_req_i), .recov_valid_o(rv_a), .recov_ready_i(recov_ready_i),
      .recov_base_o(rb_a), .recov_lane_valid_o(rlv_a), .recov_phys_o(rph_a),
      .recover_done_o(done_a), .snapshot_o(snap_a)
   );

   arch_map_table_stream #(.ARCH_REGS(60)) u_b (
      .clock(clock), .reset(reset),
      .commit_valid_i(commit_valid_i), .commit_arch_i(commit_arch_i), .commit_phys_i(commit_phys_i),
      .commit_ready_o(ready_b), .told_valid_o(tv_b), .told_phys_o(tp_b),
      .rd_arch_i(rd_arch_i), .rd_phys_o(rp_b),
      .recover_req_i(recover_req_i), .recov_valid_o(rv_b), .recov_ready_i(recov_ready_i),
      .recov_base_o(rb_b), .recov_lane_valid_o(rlv_b), .recov_phys_o(rph_b),
      .recover_done_o(done_b), .snapshot_o(snap_b)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: committed tables plus recovery position (-1 idle, 0..NB-1 streaming beat, NB done).
   int  tbl_a[];
   int  tbl_b[];
   int  rec  = -1;
   bit  live = 1'b0;

   task automatic compare_inst(input string tag, input int n, input int tbl[],
         input logic ready, input logic [CW-1:0] tv, input logic [CW-1:0][PW-1:0] tp,
         input logic [RP-1:0][PW-1:0] rp, input logic rv, input logic [AW-1:0] rb,
         input logic [RW-1:0] rlv, input logic [RW-1:0][PW-1:0] rph, input logic done,
         input logic [63:0][PW-1:0] snap);
      int tmp[];
      bit idle, strm, eff, lv;
      int a, idx;
      tmp  = tbl;
      idle = (rec == -1);
      strm = (rec >= 0) && (rec < NB);
      check({tag, ".commit_ready"}, ready, idle);
      for (int k = 0; k < CW; k++) begin
         a   = int'(commit_arch_i[k]);
         eff = commit_valid_i[k] && idle && (a != 0) && (a < n);
         check($sformatf("%s.told_valid[%0d]", tag, k), tv[k], eff);
         check($sformatf("%s.told_phys[%0d]", tag, k), tp[k], eff ? tmp[a] : 0);
         if (eff) tmp[a] = int'(commit_phys_i[k]);
      end
      for (int p = 0; p < RP; p++) begin
         if (int'(rd_arch_i[p]) < n)
            check($sformatf("%s.rd_phys[%0d]", tag, p), rp[p], tbl[rd_arch_i[p]]);
      end
      check({tag, ".recov_valid"}, rv, strm);
      check({tag, ".recov_base"}, rb, strm ? rec * RW : 0);
      for (int l = 0; l < RW; l++) begin
         idx = rec * RW + l;
         lv  = strm && (idx < n);
         check($sformatf("%s.lane_valid[%0d]", tag, l), rlv[l], lv);
         check($sformatf("%s.lane_phys[%0d]", tag, l), rph[l], lv ? tbl[idx] : 0);
      end
      check({tag, ".recover_done"}, done, rec == NB);
      for (int i = 0; i < n; i++) begin
         if (snap[i] !== PW'(tbl[i])) check($sformatf("%s.snapshot[%0d]", tag, i), snap[i], tbl[i]);
      end
   endtask

   // Single compare process: check outputs mid-cycle, then advance the model over the coming edge.
   always @(negedge clock) begin
      if (reset) begin
         tbl_a = new[64];
         tbl_b = new[60];
         for (int i = 0; i < 64; i++) tbl_a[i] = i;
         for (int i = 0; i < 60; i++) tbl_b[i] = i;
         rec  = -1;
         live = 1'b1;
      end else if (live) begin
         compare_inst("a", 64, tbl_a, ready_a, tv_a, tp_a, rp_a, rv_a, rb_a, rlv_a, rph_a, done_a, snap_a);
         compare_inst("b", 60, tbl_b, ready_b, tv_b, tp_b, rp_b, rv_b, rb_b, rlv_b, rph_b, done_b, snap_b_ext);
         if (rec == -1) begin
            for (int k = 0; k < CW; k++) begin
               if (commit_valid_i[k] && commit_arch_i[k] != 0) begin
                  tbl_a[commit_arch_i[k]] = int'(commit_phys_i[k]);
                  if (commit_arch_i[k] < 60) tbl_b[commit_arch_i[k]] = int'(commit_phys_i[k]);
               end
            end
            if (recover_req_i) rec = 0;
         end else if (rec < NB) begin
            if (recov_ready_i) rec++;
         end else begin
            rec = -1;
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic quiet();
      commit_valid_i = '0;
      commit_arch_i  = '0;
      commit_phys_i  = '0;
      recover_req_i  = 1'b0;
      recov_ready_i  = 1'b1;
   endtask

   task automatic run_to_done(input string name);
      int c;
      c = 0;
      while (!done_a && c < 40) begin
         step();
         c++;
      end
      check({name, ".done_seen"}, done_a, 1'b1);
      step();
   endtask

   initial begin
      int done_cyc;
      reset = 1'b1;
      quiet();
      rd_arch_i = '0;
      repeat (2) step();
      reset = 1'b0;

      // Identity after reset.
      rd_arch_i[0] = 6'd3;
      rd_arch_i[1] = 6'd63;
      #1;
      check("t1.rd0", rp_a[0], 3);
      check("t1.rd1", rp_a[1], 63);
      check("t1.ready", ready_a, 1);
      check("t1.snap9", snap_a[9], 9);

      // Same-cycle collision on arch 5.
      step();
      commit_valid_i = 2'b11;
      commit_arch_i[0] = 6'd5; commit_phys_i[0] = 7'd70;
      commit_arch_i[1] = 6'd5; commit_phys_i[1] = 7'd71;
      #1;
      check("t2.told0", tp_a[0], 5);
      check("t2.told1", tp_a[1], 70);
      check("t2.told_valid", tv_a, 2'b11);
      step();
      quiet();
      rd_arch_i[0] = 6'd5;
      #1;
      check("t2.rd5", rp_a[0], 71);

      // Zero register is not writable.
      commit_valid_i = 2'b01;
      commit_arch_i[0] = 6'd0; commit_phys_i[0] = 7'd90;
      #1;
      check("t3.told_valid0", tv_a[0], 0);
      step();
      quiet();
      #1;
      check("t3.snap0", snap_a[0], 0);

      // Full recovery with ready held high.
      commit_valid_i = 2'b01;
      commit_arch_i[0] = 6'd2; commit_phys_i[0] = 7'd100;
      step();
      quiet();
      recover_req_i = 1'b1;
      step();
      recover_req_i = 1'b0;
      done_cyc = 0;
      for (int c = 1; c <= 30; c++) begin
         #1;
         if (c <= NB) check($sformatf("t4.base_c%0d", c), rb_a, (c - 1) * RW);
         if (c == 1) check("t4.beat0_lane2", rph_a[2], 100);
         if (c == NB) begin
            check("t4.b_last_lanes", rlv_b, 8'h0F);
            check("t4.a_last_lanes", rlv_a, 8'hFF);
         end
         if (done_a) begin
            done_cyc = c;
            break;
         end
         step();
      end
      check("t4.done_cycle", done_cyc, 9);
      step();
      check("t4.ready_back", ready_a, 1);

      // Stall on beat 4 with commits presented.
      recover_req_i = 1'b1;
      step();
      recover_req_i = 1'b0;
      repeat (4) step();
      recov_ready_i  = 1'b0;
      commit_valid_i = 2'b11;
      commit_arch_i[0] = 6'd33; commit_phys_i[0] = 7'd1;
      commit_arch_i[1] = 6'd34; commit_phys_i[1] = 7'd2;
      for (int s = 0; s < 3; s++) begin
         #1;
         check($sformatf("t5.base_s%0d", s), rb_a, 32);
         check($sformatf("t5.lane1_s%0d", s), rph_a[1], 33);
         check($sformatf("t5.told_valid_s%0d", s), tv_a, 0);
         step();
      end
      quiet();
      run_to_done("t5");
      check("t5.snap33", snap_a[33], 33);

      // Reset during beat 3.
      recover_req_i = 1'b1;
      step();
      recover_req_i = 1'b0;
      repeat (3) step();
      check("t6.mid_stream", rb_a, 24);
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      check("t6.recov_valid", rv_a, 0);
      check("t6.done", done_a, 0);
      check("t6.snap5", snap_a[5], 5);
      check("t6.ready", ready_a, 1);
      repeat (12) step();

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < CW; k++) begin
            commit_valid_i[k] = ($urandom_range(0, 2) != 0);
            commit_arch_i[k]  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 3))
                                                             : 6'($urandom_range(0, 59));
            commit_phys_i[k]  = 7'($urandom_range(0, 127));
         end
         for (int p = 0; p < RP; p++) rd_arch_i[p] = 6'($urandom_range(0, 63));
         recover_req_i = ($urandom_range(0, 24) == 0);
         recov_ready_i = ($urandom_range(0, 3) != 0);
         step();
      end
      quiet();
      repeat (20) step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/arch_map_table_stream.md
Name: arch_map_table_stream

Overview:
- Committed (architectural) register map for the R10K-style core, parametrised in commit width, lookup ports and recovery bandwidth.
- Updated at retire; returns each displaced physical register (Told) to the free list.
- On mispredict/exception, streams the committed map to the speculative RAT over several cycles through a valid/ready recovery channel.
- Sits between ROB retire, free list and speculative map table.

Parameters:
- ARCH_REGS, 64: architectural registers; AW = $clog2(ARCH_REGS).
- PHYS_REGS, 128: physical registers; PW = $clog2(PHYS_REGS). Must be >= ARCH_REGS.
- COMMIT_WIDTH, 2: retire slots per cycle; slot 0 is oldest.
- READ_PORTS, 2: combinational lookup ports.
- RECOVER_WIDTH, 8: map entries per recovery beat. NBEATS = ceil(ARCH_REGS/RECOVER_WIDTH).
- ZERO_REG_EN, 1: when 1, arch reg 0 is hardwired to phys 0 and never written.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- commit_valid_i  in  COMMIT_WIDTH  per-slot valid retire.
- commit_arch_i  in  COMMIT_WIDTH x AW  destination arch reg.
- commit_phys_i  in  COMMIT_WIDTH x PW  new committed phys reg.
- commit_ready_o  out  1  high only in IDLE; ROB must not retire while low.
- told_valid_o  out  COMMIT_WIDTH  displaced phys reg valid, to free list.
- told_phys_o  out  COMMIT_WIDTH x PW  displaced phys reg.
- rd_arch_i  in  READ_PORTS x AW  lookup index.
- rd_phys_o  out  READ_PORTS x PW  committed mapping.
- recover_req_i  in  1  start recovery; sampled in IDLE only.
- recov_valid_o  out  1  recovery beat valid.
- recov_ready_i  in  1  RAT accepts beat.
- recov_base_o  out  AW  arch index of lane 0 in the current beat.
- recov_lane_valid_o  out  RECOVER_WIDTH  per-lane valid.
- recov_phys_o  out  RECOVER_WIDTH x PW  mapping for arch index recov_base_o+lane.
- recover_done_o  out  1  one-cycle pulse after the last beat is accepted.
- snapshot_o  out  ARCH_REGS x PW  full committed map, registered state.

Behaviour:
- Reset (synchronous, wins over all other inputs, including mid-recovery):
  - table[i] = i; FSM returns to IDLE; beat counter = 0.
  - commit_ready_o = 1; all other outputs 0 except snapshot_o = identity and rd_phys_o reflecting the identity table.
- Commit (IDLE only):
  - Slot updates are applied in ascending slot order in one cycle. If slots collide on one arch reg, the highest valid slot's phys wins.
  - told_phys_o[k] is combinational and equals the mapping of commit_arch_i[k] seen after applying valid slots 0..k-1 of the same cycle. This forwards from earlier slots, so a colliding younger slot frees the older slot's new phys, not the table value.
  - told_valid_o[k] = commit_valid_i[k] && commit_ready_o && !(ZERO_REG_EN && commit_arch_i[k]==0).
  - Commits with arch 0 under ZERO_REG_EN are dropped: no write, no Told.
  - Table writes take effect at the next clock edge.
- Lookup:
  - rd_phys_o[p] = table[rd_arch_i[p]], combinational from registered state.
  - No same-cycle commit bypass.
- Recovery FSM:
  - States: IDLE, STREAM, DONE.
  - IDLE -> STREAM when recover_req_i = 1. Commits presented in that same cycle are still applied, and the stream reflects them.
  - STREAM: recov_valid_o = 1; recov_base_o = beat * RECOVER_WIDTH. Lane l is valid iff base+l < ARCH_REGS. Invalid lanes drive phys 0.
  - A beat advances only when recov_valid_o && recov_ready_i. Outputs hold stable while ready is low, with no cycle limit.
  - Acceptance of beat NBEATS-1 -> DONE. recover_done_o = 1 for exactly that one DONE cycle, then DONE -> IDLE.
  - In STREAM and DONE: commit_ready_o = 0, commit_valid_i is ignored (no write, told_valid_o = 0), and recover_req_i is ignored.
  - Minimum recovery latency, with ready held high: request cycle + NBEATS + 1 cycles until commit_ready_o returns.
  - Table contents never change outside IDLE.
- snapshot_o always equals the current registered table.

Test Plan:
1. Reset, then read ports 3 and 63 -> rd_phys_o = 3 and 63. snapshot_o is identity, commit_ready_o = 1.
2. Slot0 commits arch5->phys70, slot1 commits arch5->phys71, same cycle -> told_phys_o = {5, 70} (slot0, slot1), both told valid. Next cycle table[5] = 71.
3. ZERO_REG_EN = 1, commit arch0->phys90 -> told_valid_o[0] = 0; table[0] stays 0.
4. Commit arch2->phys100, then recover_req_i with recov_ready_i always 1:
   - 8 beats with base 0, 8, ..., 56; beat 0 lane 2 = 100.
   - recover_done_o pulses in cycle 9 after the request.
   - commit_ready_o = 0 throughout STREAM and DONE.
5. During STREAM, drop recov_ready_i for 3 cycles on beat 4 -> base holds at 32 with data unchanged. Commit_valid_i asserted during the stall -> no table change, told_valid_o = 0.
6. Reset asserted mid-STREAM (beat 3) -> next cycle IDLE, recov_valid_o = 0, identity table, no recover_done_o pulse. Also covers ARCH_REGS = 60 with RECOVER_WIDTH = 8: the final beat has lanes 4..7 invalid.
